// File: rtl/clk_div_ctrl_pkg.sv
// Shared constants for the programmable clock divider: FSM encodings and ratio floor.
package clk_div_ctrl_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam int unsigned MIN_DIV = 2;
endpackage

// File: rtl/clk_div_ctrl_core.sv
// Period counter, high/low phase compare and end-of-period tick decode for one ratio.
module clk_div_core
  import clk_div_ctrl_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             active_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic [DIV_W-1:0] high;

  // Odd ratios put the extra cycle in the high phase.
  assign high   = div_i - (div_i >> 1);
  assign tick_o = active_i && (cnt_q == div_i - DIV_W'(1));

  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    if (start_i) begin
      cnt_d     = '0;
      clk_out_d = 1'b1;
    end else if (tick_o) begin
      cnt_d     = '0;
      clk_out_d = !stop_i;
    end else if (active_i) begin
      cnt_d     = cnt_q + DIV_W'(1);
      clk_out_d = (cnt_d < high);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out_o = clk_out_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider: FSM, ratio handshake and active/pending ratio registers.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  output logic             cfg_ready_o,
  output logic             cfg_done_o,
  output logic             cfg_err_o,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] MIN_D = DIV_W'(MIN_DIV);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             start, stop, tick, xfer, legal, active;

  assign active      = (state_q != ST_IDLE);
  assign cfg_ready_o = (state_q != ST_PEND);
  assign xfer        = cfg_valid_i && cfg_ready_o;
  assign legal       = (cfg_div_i >= MIN_D);

  always_comb begin
    state_d    = state_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    done_d     = 1'b0;
    err_d      = xfer && !legal;
    start      = 1'b0;
    stop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer && legal) begin
          div_act_d = cfg_div_i;
          done_d    = 1'b1;
        end
        if (en_i) begin
          state_d = ST_RUN;
          start   = 1'b1;
        end
      end
      ST_RUN: begin
        // A ratio landing on the final edge of a stopping run is applied as if in IDLE.
        if (tick && !en_i) begin
          state_d = ST_IDLE;
          stop    = 1'b1;
          if (xfer && legal) begin
            div_act_d = cfg_div_i;
            done_d    = 1'b1;
          end
        end else if (xfer && legal) begin
          div_pend_d = cfg_div_i;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (tick) begin
          div_act_d = div_pend_q;
          done_d    = 1'b1;
          state_d   = en_i ? ST_RUN : ST_IDLE;
          stop      = !en_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      div_act_q  <= DIV_W'(DEF_DIV);
      div_pend_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .active_i  (active),
    .start_i   (start),
    .stop_i    (stop),
    .div_i     (div_act_q),
    .clk_out_o (clk_out_o),
    .tick_o    (tick)
  );

  assign tick_o     = tick;
  assign busy_o     = active;
  assign cfg_done_o = done_q;
  assign cfg_err_o  = err_q;

endmodule
